// File: rtl/seven_segment_pkg.sv
// seven_segment_pkg: hex glyph table, digit count and FSM state type shared by the seven-segment capture.
package seven_segment_pkg;
  localparam int DIGITS = 8;
  localparam logic [6:0] GLYPH_0 = 7'b0000001;
  localparam logic [6:0] GLYPH_1 = 7'b1001111;
  localparam logic [6:0] GLYPH_2 = 7'b0010010;
  localparam logic [6:0] GLYPH_3 = 7'b0000110;
  localparam logic [6:0] GLYPH_4 = 7'b1001100;
  localparam logic [6:0] GLYPH_5 = 7'b0100100;
  localparam logic [6:0] GLYPH_6 = 7'b0100000;
  localparam logic [6:0] GLYPH_7 = 7'b0001111;
  localparam logic [6:0] GLYPH_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_9 = 7'b0000100;
  localparam logic [6:0] GLYPH_A = 7'b0001000;
  localparam logic [6:0] GLYPH_B = 7'b1100000;
  localparam logic [6:0] GLYPH_C = 7'b0110001;
  localparam logic [6:0] GLYPH_D = 7'b1000010;
  localparam logic [6:0] GLYPH_E = 7'b0110000;
  localparam logic [6:0] GLYPH_F = 7'b0111000;
  localparam logic [6:0] GLYPHS [16] = '{GLYPH_0, GLYPH_1, GLYPH_2, GLYPH_3, GLYPH_4, GLYPH_5,
                                        GLYPH_6, GLYPH_7, GLYPH_8, GLYPH_9, GLYPH_A, GLYPH_B,
                                        GLYPH_C, GLYPH_D, GLYPH_E, GLYPH_F};
  typedef enum logic {IDLE, COLLECT} state_e;
endpackage

// File: rtl/seven_segment_glyph_match.sv
// seven_segment_glyph_match: combinational lookup of active-low segments a..g to a hex nibble.
module seven_segment_glyph_match
  import seven_segment_pkg::*;
(
  input  logic [6:0] seg,
  output logic       hit,
  output logic [3:0] nibble
);
  always_comb begin
    hit = 1'b0;
    nibble = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (seg == GLYPHS[i]) begin
        hit = 1'b1;
        nibble = 4'(i);
      end
    end
  end
endmodule

// File: rtl/seven_segment_capture.sv
// seven_segment_capture: reconstructs the value shown on a multiplexed 8-digit hex display.
// Define SEVEN_SEGMENT_DP_CAPTURE_EN to add the captured decimal-point output dp.
module seven_segment_capture
  import seven_segment_pkg::*;
#(
  parameter int TIMEOUT     = 1024,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  id,
  input  logic [7:0]  seg,
  output logic [31:0] value,
  output logic [7:0]  blank,
  output logic        valid,
`ifdef SEVEN_SEGMENT_DP_CAPTURE_EN
  output logic [7:0]  dp,
`endif
  output logic        err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  logic [SYNC_STAGES-1:0][7:0] id_sync_q, id_sync_d, seg_sync_q, seg_sync_d;
  state_e      state_q, state_d;
  logic [31:0] shadow_q, shadow_d, value_q, value_d;
  logic [7:0]  seen_q, seen_d, blank_q, blank_d;
  logic [2:0]  last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        ferr_q, ferr_d, err_q, err_d, valid_q, valid_d;
  logic [7:0]  id_s, seg_s;
  logic [2:0]  k;
  logic        one, idle, close, open, hit;
  logic [3:0]  nibble;
`ifdef SEVEN_SEGMENT_DP_CAPTURE_EN
  logic [7:0]  dps_q, dps_d, dp_q, dp_d;
`else
  logic        unused_dp;
  assign unused_dp = seg_s[0];
`endif

  assign id_s  = id_sync_q[SYNC_STAGES-1];
  assign seg_s = seg_sync_q[SYNC_STAGES-1];

  seven_segment_glyph_match u_match (.seg(seg_s[7:1]), .hit(hit), .nibble(nibble));

  always_comb begin
    id_sync_d[0] = id;
    seg_sync_d[0] = seg;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      id_sync_d[i] = id_sync_q[i-1];
      seg_sync_d[i] = seg_sync_q[i-1];
    end
    k = 3'd0;
    for (int i = 0; i < DIGITS; i++) if (!id_s[i]) k = 3'(i);
    one = $countones(~id_s) == 1;
    idle = id_s == 8'hFF;
    state_d = state_q;
    shadow_d = shadow_q;
    seen_d = seen_q;
    ferr_d = ferr_q;
    last_d = last_q;
    cnt_d = cnt_q;
    value_d = value_q;
    blank_d = blank_q;
    err_d = err_q;
    valid_d = 1'b0;
`ifdef SEVEN_SEGMENT_DP_CAPTURE_EN
    dps_d = dps_q;
    dp_d = dp_q;
`endif
    close = 1'b0;
    // A repeat of the last digit only starts a new frame once an idle gap separated the two dwells
    if (state_q == COLLECT) begin
      if (one) close = k < last_q || (k == last_q && cnt_q != '0);
      else if (idle) begin
        cnt_d = (cnt_q == TMAX) ? cnt_q : cnt_q + 1'b1;
        close = cnt_d == TMAX;
        state_d = close ? IDLE : state_q;
      end else ferr_d = 1'b1;
    end
    open = one && (state_q == IDLE || close);
    if (close) begin
      value_d = shadow_q;
      blank_d = ~seen_q;
      err_d = ferr_q;
      valid_d = 1'b1;
`ifdef SEVEN_SEGMENT_DP_CAPTURE_EN
      dp_d = dps_q;
`endif
    end
    if (open) begin
      state_d = COLLECT;
      shadow_d = '0;
      seen_d = '0;
      ferr_d = 1'b0;
`ifdef SEVEN_SEGMENT_DP_CAPTURE_EN
      dps_d = '0;
`endif
    end
    if (one) begin
      if (hit) shadow_d[{k, 2'b00} +: 4] = nibble;
      else ferr_d = 1'b1;
      seen_d[k] = 1'b1;
      last_d = k;
      cnt_d = '0;
`ifdef SEVEN_SEGMENT_DP_CAPTURE_EN
      dps_d[k] = ~seg_s[0];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_sync_q <= '0;
      seg_sync_q <= '0;
      state_q <= IDLE;
      shadow_q <= '0;
      seen_q <= '0;
      ferr_q <= 1'b0;
      last_q <= '0;
      cnt_q <= '0;
      value_q <= '0;
      blank_q <= 8'hFF;
      err_q <= 1'b0;
      valid_q <= 1'b0;
`ifdef SEVEN_SEGMENT_DP_CAPTURE_EN
      dps_q <= '0;
      dp_q <= '0;
`endif
    end else begin
      id_sync_q <= id_sync_d;
      seg_sync_q <= seg_sync_d;
      state_q <= state_d;
      shadow_q <= shadow_d;
      seen_q <= seen_d;
      ferr_q <= ferr_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
      value_q <= value_d;
      blank_q <= blank_d;
      err_q <= err_d;
      valid_q <= valid_d;
`ifdef SEVEN_SEGMENT_DP_CAPTURE_EN
      dps_q <= dps_d;
      dp_q <= dp_d;
`endif
    end
  end

  assign value = value_q;
  assign blank = blank_q;
  assign err   = err_q;
  assign valid = valid_q;
`ifdef SEVEN_SEGMENT_DP_CAPTURE_EN
  assign dp    = dp_q;
`endif
endmodule

// File: tb/tb_seven_segment_capture.sv
// tb_seven_segment_capture: directed and random display scans checked against a frame-level model.
module tb_seven_segment_capture;
  localparam int TIMEOUT = 1024;
  localparam int SYNC = 2;
  localparam int LAT = SYNC + 1;

  logic clk = 1'b0, rst_n = 1'b1;
  logic [7:0] id = 8'hFF, seg = 8'hFF;
  logic [31:0] value;
  logic [7:0] blank;
  logic valid, err;
`ifdef SEVEN_SEGMENT_DP_CAPTURE_EN
  logic [7:0] dp;
`endif

  seven_segment_capture #(.TIMEOUT(TIMEOUT), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .id(id), .seg(seg), .value(value), .blank(blank), .valid(valid),
`ifdef SEVEN_SEGMENT_DP_CAPTURE_EN
    .dp(dp),
`endif
    .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int n;
    logic [31:0] v;
    logic [7:0] b;
    logic e;
    logic [7:0] d;
  } frame_t;

  frame_t exp_q[$];
  logic [6:0] glyph [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100,
                             7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                             7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
  int checks = 0, errors = 0, cyc = 0, nvalid = 0, nv0 = 0;
  bit m_open = 0;
  int m_last = 0, m_gap = 0;
  logic [31:0] m_val = '0, p_val = '0;
  logic [7:0] m_seen = '0, m_dp = '0, p_blank = 8'hFF, p_dp = '0;
  logic m_err = 0, p_err = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 20) $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void m_close(int n);
    frame_t f;
    f.n = n; f.v = m_val; f.b = ~m_seen; f.e = m_err; f.d = m_dp;
    exp_q.push_back(f);
    m_open = 0;
  endfunction

  // One display sample: a frame is the set of digits lit between two wraps of the scan order.
  function automatic void model(int n, logic [7:0] i, logic [7:0] s);
    int lows = 0, k = 0, g = -1;
    for (int b = 0; b < 8; b++) if (!i[b]) begin lows++; k = b; end
    if (lows == 1) begin
      if (m_open && (k < m_last || (k == m_last && m_gap > 0))) m_close(n);
      if (!m_open) begin m_open = 1; m_val = '0; m_seen = '0; m_err = 0; m_dp = '0; end
      for (int j = 0; j < 16; j++) if (glyph[j] == s[7:1]) g = j;
      if (g < 0) m_err = 1; else m_val[4*k +: 4] = 4'(g);
      m_seen[k] = 1'b1; m_dp[k] = ~s[0]; m_last = k; m_gap = 0;
    end else if (m_open) begin
      if (lows == 0) begin
        m_gap++;
        if (m_gap == TIMEOUT) m_close(n);
      end else m_err = 1;
    end
  endfunction

  task automatic step(logic [7:0] i, logic [7:0] s);
    logic ev;
    @(negedge clk);
    ev = exp_q.size() > 0 && exp_q[0].n + LAT == cyc;
    if (ev) begin
      p_val = exp_q[0].v; p_blank = exp_q[0].b; p_err = exp_q[0].e; p_dp = exp_q[0].d;
      void'(exp_q.pop_front());
    end
    check("valid", valid, ev);
    if (valid) nvalid++;
    check("value", value, p_val);
    check("blank", blank, p_blank);
    check("err", err, p_err);
`ifdef SEVEN_SEGMENT_DP_CAPTURE_EN
    check("dp", dp, p_dp);
`endif
    id = i; seg = s;
    model(cyc, i, s);
    cyc++;
  endtask

  task automatic sel(int k, logic [6:0] g);
    step(~(8'd1 << k), {g, 1'($urandom)});
  endtask

  task automatic idle(int n);
    repeat (n) step(8'hFF, 8'($urandom));
  endtask

  task automatic scan(logic [31:0] v, logic [7:0] skip, int dwell);
    for (int k = 0; k < 8; k++)
      for (int d = 0; d < dwell; d++)
        if (skip[k]) step(8'hFF, 8'hFF); else sel(k, glyph[v[4*k +: 4]]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; id = 8'hFF; seg = 8'hFF;
    #1;
    check("rst_value", value, 32'h0);
    check("rst_blank", blank, 8'hFF);
    check("rst_valid", valid, 1'b0);
    check("rst_err", err, 1'b0);
    exp_q.delete();
    m_open = 0; p_val = '0; p_blank = 8'hFF; p_err = 0; p_dp = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    // Clean scans: the wrap to digit 0 closes the previous frame
    scan(32'h1234ABCD, 8'h00, 4);
    scan(32'h1234ABCD, 8'h00, 4);
    idle(LAT + 1);
    check("r29_value", value, 32'h1234ABCD);
    check("r29_blank", blank, 8'h00);
    check("r29_err", err, 1'b0);
    scan(32'h1234ABCD, 8'hC0, 4);
    scan(32'h1234ABCD, 8'hC0, 4);
    idle(LAT + 1);
    check("r30_value", value, 32'h0034ABCD);
    check("r30_blank", blank, 8'hC0);
    check("r30_err", err, 1'b0);
    nv0 = nvalid;
    idle(TIMEOUT + 8);
    check("r31_valids", nvalid - nv0, 1);
    scan(32'hCAFEF00D, 8'h00, 3);
    nv0 = nvalid;
    idle(TIMEOUT + 8);
    check("r31_single", nvalid - nv0, 1);
    check("r31_value", value, 32'hCAFEF00D);
    // An idle gap one short of the timeout keeps the frame open
    for (int k = 0; k < 4; k++) sel(k, glyph[k + 8]);
    idle(TIMEOUT - 1);
    for (int k = 4; k < 8; k++) sel(k, glyph[k + 8]);
    sel(0, glyph[0]);
    idle(LAT + 1);
    check("gap_value", value, 32'hFEDCBA98);
    for (int k = 0; k < 8; k++) sel(k, k == 3 ? 7'h7F : glyph[k]);
    sel(0, glyph[0]);
    idle(LAT + 1);
    check("r32_err", err, 1'b1);
    check("r32_nib3", value[15:12], 4'h0);
    check("r32_blank3", blank[3], 1'b0);
    idle(TIMEOUT + 4);
    for (int k = 0; k < 8; k++) begin
      sel(k, glyph[7 - k]);
      if (k == 2) step(8'hF3, 8'hFF);
      sel(k, glyph[7 - k]);
    end
    scan(32'h89ABCDEF, 8'h00, 2);
    idle(LAT + 1);
    check("r33_err", err, 1'b1);
    sel(0, glyph[15]);
    idle(LAT + 1);
    check("r33_clean", err, 1'b0);
    check("r33_value", value, 32'h89ABCDEF);
    for (int k = 0; k < 5; k++) sel(k, glyph[k]);
    do_reset();
    scan(32'h5A5A0FF0, 8'h00, 3);
    sel(0, glyph[1]);
    idle(LAT + 1);
    check("r34_value", value, 32'h5A5A0FF0);
    check("r34_blank", blank, 8'h00);
    idle(TIMEOUT + 4);
    for (int r = 0; r < 200; r++) begin
      logic [31:0] v = $urandom;
      logic [7:0] skip = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      int dwell = $urandom_range(1, 5);
      for (int k = 0; k < 8; k++)
        for (int d = 0; d < dwell; d++) begin
          if ($urandom_range(0, 40) == 0) step(8'($urandom), 8'($urandom));
          else if (skip[k]) step(8'hFF, 8'($urandom));
          else sel(k, ($urandom_range(0, 30) == 0) ? 7'($urandom) : glyph[v[4*k +: 4]]);
        end
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 30));
      if (r % 50 == 49) do_reset();
    end
    idle(TIMEOUT + LAT + 4);
    check("drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seven_segment_capture.md
SEVEN_SEGMENT_CAPTURE -- requirements
Module: seven_segment_capture

Interface
REQ-001 Parameter TIMEOUT, default 1024, SHALL be the number of clk cycles with no digit selected after which an open frame closes.
REQ-002 Parameter SYNC_STAGES, default 2, SHALL be the synchronizer depth applied to id and seg.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: asynchronous assert, active-low.
REQ-005 id  input  8  SHALL be the active-low digit select; bit k low selects digit k.
REQ-006 seg  input  8  SHALL be the active-low segment bus; bits [7:1] are a..g, bit 0 is the decimal point.
REQ-007 value  output  32  SHALL carry the last completed frame; digit k occupies bits [4k+3:4k].
REQ-008 blank  output  8  SHALL mark the digits not selected during the last completed frame (1 = blank).
REQ-009 valid  output  1  SHALL pulse high for one cycle when value/blank/err update.
REQ-010 err  output  1  SHALL flag a defect in the last completed frame.

Function
REQ-011 id and seg SHALL pass through SYNC_STAGES flops before use; all latencies below count from synchronizer output.
REQ-012 The block SHALL recognise the 16 hex glyphs: 0=0000001,1=1001111,2=0010010,3=0000110,4=1001100,5=0100100,6=0100000,7=0001111,8=0000000,9=0000100,A=0001000,b=1100000,C=0110001,d=1000010,E=0110000,F=0111000 (seg[7:1]).
REQ-013 A sample with exactly one id bit low SHALL be a "selection" of index k; id==8'hFF SHALL be "idle"; two or more low bits SHALL set the frame error flag and be otherwise ignored.
REQ-014 FSM states SHALL be IDLE and COLLECT; reset enters IDLE.
REQ-015 IDLE: on a selection, go to COLLECT, clear shadow value, clear seen mask, clear frame error, then record the selection.
REQ-016 COLLECT, recording selection k: shadow nibble k <= decoded glyph, seen[k] <= 1; last index <= k; idle counter <= 0.
REQ-017 Consecutive samples with the same k SHALL be treated as one dwell; latest glyph wins.
REQ-018 An unrecognised seg[7:1] pattern during a selection SHALL set frame error and leave shadow nibble k unchanged, seen[k] still set.
REQ-019 COLLECT: a selection with k < last index (wrap) SHALL close the frame and, in the same cycle, open a new frame seeded by k (as REQ-015).
REQ-020 COLLECT: a selection of a k already seen with k > last index is impossible by REQ-019; k == last index after an idle gap SHALL also close and reopen.
REQ-021 COLLECT: idle counter SHALL increment on idle samples and saturate; reaching TIMEOUT SHALL close the frame and return to IDLE.
REQ-022 Frame close SHALL register value <= shadow, blank <= ~seen, err <= frame error, valid <= 1 on the next clock edge (1-cycle latency); unseen nibbles read 0.
REQ-023 Outputs SHALL hold between valid pulses.

Reset
REQ-024 rst_n low SHALL immediately force value=0, blank=8'hFF, valid=0, err=0, state IDLE, synchronizers and counters cleared.
REQ-025 Reset mid-frame SHALL discard the open frame; no valid pulse for it.

Configuration
REQ-026 Macro SEVEN_SEGMENT_DP_CAPTURE_EN defined: output dp[7:0] SHALL be added, capturing ~seg[0] per digit into the frame like value (reset 0); undefined: port absent, seg[0] ignored.

Structure
REQ-027 Package seven_segment_pkg SHALL hold the 16 glyph constants, DIGITS=8 and the FSM state typedef.
REQ-028 Sub-module seven_segment_glyph_match SHALL map seg[7:1] to {hit, nibble} combinationally.

Verification
REQ-029 Scan 0x1234ABCD, digits 0..7 each 4 cycles, repeated -> valid pulse, value=0x1234ABCD, blank=8'h00, err=0.
REQ-030 Same scan with digits 6,7 never selected (id=8'hFF in their slots) -> value=0x0034ABCD, blank=8'hC0, err=0.
REQ-031 One frame then id=8'hFF for 1024 cycles -> frame closes on timeout, returns IDLE, single valid.
REQ-032 Digit 3 shows seg[7:1]=1111111 -> err=1, nibble 3 = 0, blank[3]=0.
REQ-033 id=8'hF3 for one cycle mid-frame -> err=1 on that frame only; next clean frame err=0.
REQ-034 rst_n pulsed low mid-frame -> outputs at reset values, next full frame reported correctly.
